pe_sequencer: RTL and testbench

//  Control FSM for one PE tile. Drives the kernel buffer load, the 16-tap MAC sweep over the kernel mux,

---
 rtl/pe_seq_pkg.sv | 23 ++
 rtl/pe_seq_addr_gen.sv | 25 ++
 rtl/pe_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_pe_sequencer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_seq_pkg.sv
// Shared state encoding and default geometry for the PE tile sequencer.
package pe_seq_pkg;

  localparam int TAPS_DEF    = 16;
  localparam int K_WORDS_DEF = 4;
  localparam int BPW_DEF     = 4;
  localparam int ADDR_W_DEF  = 9;

  // Tap counter drives the 4-bit kernel mux select directly.
  localparam int TAP_W  = $clog2(TAPS_DEF);
  localparam int BCNT_W = $clog2(BPW_DEF + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_K,
    CLR,
    MAC,
    STORE,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/pe_seq_addr_gen.sv
// OFM word address counter: clear on job start, +1 per word write, wraps mod 2^ADDR_W.
// Latency: new address visible the cycle after clr/inc; no backpressure.
module pe_seq_addr_gen
  import pe_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (inc) begin
      addr <= addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/pe_sequencer.sv
// PE tile control FSM: kernel load, 16-tap MAC sweep, byte packing, OFM word writes; window = TAPS+2 cycles (+1 per WRITE).
// Backpressure: k_valid/in_valid low stalls LOAD_K/MAC in place. Optional PE_SEQ_PERF_EN adds perf_stall.
module pe_sequencer
  import pe_seq_pkg::*;
#(
  parameter int TAPS    = TAPS_DEF,
  parameter int K_WORDS = K_WORDS_DEF,
  parameter int BPW     = BPW_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_win,
  input  logic              k_valid,
  output logic              k_ready,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              buf4x4_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [3:0]        sel,
  output logic              Mac_en,
  output logic              Mac_rst,
  output logic              shift_rst,
  output logic              shift_write,
  output logic              shif_shift,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done
`ifdef PE_SEQ_PERF_EN
  ,
  output logic [15:0]       perf_stall
`endif
);

  localparam int BC_W = $clog2(BPW + 1);

  state_t            state;
  logic [ADDR_W-1:0] win_lim;
  logic [ADDR_W-1:0] kcnt;
  logic [TAP_W-1:0]  tap;
  logic [BC_W-1:0]   bcnt;
  logic [ADDR_W-1:0] win;
  logic [BC_W-1:0]   bcnt_nxt;
  logic [ADDR_W-1:0] win_nxt;
  logic              job_start;

  assign job_start = (state == IDLE) && start;
  assign bcnt_nxt  = bcnt + BC_W'(1);
  assign win_nxt   = win + ADDR_W'(1);

  // Handshake strobes follow the registered ready so a transfer is same-cycle.
  assign buf4x4_we = k_valid & k_ready;
  assign Mac_en    = in_valid & in_ready;
  assign buf_addr  = kcnt;
  assign sel       = tap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      win_lim     <= '0;
      kcnt        <= '0;
      tap         <= '0;
      bcnt        <= '0;
      win         <= '0;
      k_ready     <= 1'b0;
      in_ready    <= 1'b0;
      Mac_rst     <= 1'b0;
      shift_rst   <= 1'b0;
      shift_write <= 1'b0;
      shif_shift  <= 1'b0;
      wr          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      Mac_rst     <= 1'b0;
      shift_rst   <= 1'b0;
      shift_write <= 1'b0;
      shif_shift  <= 1'b0;
      wr          <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            win_lim   <= num_win;
            kcnt      <= '0;
            tap       <= '0;
            bcnt      <= '0;
            win       <= '0;
            shift_rst <= 1'b1;
            busy      <= 1'b1;
            k_ready   <= 1'b1;
            state     <= LOAD_K;
          end
        end
        LOAD_K: begin
          if (k_valid) begin
            if (kcnt == ADDR_W'(K_WORDS - 1)) begin
              kcnt    <= '0;
              k_ready <= 1'b0;
              Mac_rst <= 1'b1;
              state   <= CLR;
            end else begin
              kcnt <= kcnt + ADDR_W'(1);
            end
          end
        end
        CLR: begin
          // Only reachable with win==win_lim when the job has zero windows.
          if (win == win_lim) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= MAC;
          end
        end
        MAC: begin
          if (in_valid) begin
            if (tap == TAP_W'(TAPS - 1)) begin
              tap         <= '0;
              in_ready    <= 1'b0;
              shift_write <= 1'b1;
              shif_shift  <= 1'b1;
              state       <= STORE;
            end else begin
              tap <= tap + TAP_W'(1);
            end
          end
        end
        STORE: begin
          bcnt <= bcnt_nxt;
          win  <= win_nxt;
          if (bcnt_nxt == BC_W'(BPW) || win_nxt == win_lim) begin
            wr    <= 1'b1;
            state <= WRITE;
          end else begin
            Mac_rst <= 1'b1;
            state   <= CLR;
          end
        end
        WRITE: begin
          bcnt <= '0;
          if (win == win_lim) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            shift_rst <= 1'b1;
            Mac_rst   <= 1'b1;
            state     <= CLR;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  pe_seq_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (job_start),
    .inc  (state == WRITE),
    .addr (addr)
  );

`ifdef PE_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall <= '0;
    end else if (job_start) begin
      perf_stall <= '0;
    end else if (state == MAC && !in_valid && perf_stall != 16'hFFFF) begin
      perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_sequencer.sv
// Self-checking bench for pe_sequencer: randomized kernel/IFM gaps against a spec-level job model.
module tb_pe_sequencer;

  localparam int TAPS    = 16;
  localparam int K_WORDS = 4;
  localparam int BPW     = 4;
  localparam int ADDR_W  = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] num_win = '0;
  logic              k_valid = 1'b0;
  logic              in_valid = 1'b0;
  logic              k_ready, in_ready, buf4x4_we, Mac_en, Mac_rst, shift_rst;
  logic              shift_write, shif_shift, wr, busy, done;
  logic [ADDR_W-1:0] buf_addr, addr;
  logic [3:0]        sel;
`ifdef PE_SEQ_PERF_EN
  logic [15:0]       perf_stall;
`endif

  pe_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_win     (num_win),
    .k_valid     (k_valid),
    .k_ready     (k_ready),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .buf4x4_we   (buf4x4_we),
    .buf_addr    (buf_addr),
    .sel         (sel),
    .Mac_en      (Mac_en),
    .Mac_rst     (Mac_rst),
    .shift_rst   (shift_rst),
    .shift_write (shift_write),
    .shif_shift  (shif_shift),
    .wr          (wr),
    .addr        (addr),
    .busy        (busy),
    .done        (done)
`ifdef PE_SEQ_PERF_EN
    ,
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event monitor, sampled on the falling edge; cycle 0 is the start cycle.
  logic mon_clr = 1'b0;
  int   cyc, we_cnt, we_bad, mac_cnt, sel_bad, sw_cnt, sw_mark, ss_bad;
  int   done_cnt, done_cyc, done_busy_bad;
  int   wr_addr[$];
  int   wr_bytes[$];

  always @(negedge clk) begin
    if (mon_clr) begin
      cyc = 0; we_cnt = 0; we_bad = 0; mac_cnt = 0; sel_bad = 0; sw_cnt = 0;
      sw_mark = 0; ss_bad = 0; done_cnt = 0; done_cyc = -1; done_busy_bad = 0;
      wr_addr.delete();
      wr_bytes.delete();
    end else begin
      cyc++;
      if (buf4x4_we) begin
        if (int'(buf_addr) != we_cnt) we_bad++;
        we_cnt++;
      end
      if (in_ready && int'(sel) != (mac_cnt % TAPS)) sel_bad++;
      if (Mac_en) mac_cnt++;
      if (shift_write) begin
        sw_cnt++;
        if (!shif_shift) ss_bad++;
      end
      if (wr) begin
        wr_addr.push_back(int'(addr));
        wr_bytes.push_back(sw_cnt - sw_mark);
        sw_mark = sw_cnt;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy) done_busy_bad++;
      end
    end
  end

  // Job timing model: LOAD_K words, then per window CLR + TAPS MACs + STORE, one cycle per word write.
  function automatic int exp_done_cyc(input int nw, input int kg, input int st);
    if (nw == 0) return K_WORDS + kg + 2;
    return K_WORDS + kg + (TAPS + 2) * nw + st + (nw + BPW - 1) / BPW + 1;
  endfunction

  // Drives one job; the sources insert random gaps only while the DUT is ready, and total them.
  task automatic run_job(input int nw, input int kmax, input int imax, input int bogus_at,
                         input int abort_tap, output int exp_kgap, output int exp_stall,
                         output bit aborted);
    int kgap, igap, kcons, icons, total;
    aborted   = 1'b0;
    total     = nw * TAPS;
    kgap      = int'($urandom_range(kmax));
    exp_kgap  = kgap;
    igap      = (total > 0) ? int'($urandom_range(imax)) : 0;
    exp_stall = igap;
    kcons     = 0;
    icons     = 0;
    @(posedge clk); #1;
    start   = 1'b1;
    num_win = ADDR_W'(nw);
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    start   = 1'b0;
    for (int c = 1; c < 4000; c++) begin
      num_win = ADDR_W'($urandom);
      start   = (c == bogus_at);
      if (done_cnt > 0) break;
      if (abort_tap >= 0 && in_ready && int'(sel) == abort_tap) begin
        aborted = 1'b1;
        break;
      end
      if (k_ready) begin
        if (kgap > 0) begin
          k_valid = 1'b0;
          kgap--;
        end else begin
          k_valid = 1'b1;
          kcons++;
          if (kcons < K_WORDS) begin
            kgap = int'($urandom_range(kmax));
            exp_kgap += kgap;
          end
        end
      end else begin
        k_valid = 1'($urandom);
      end
      if (in_ready) begin
        if (igap > 0) begin
          in_valid = 1'b0;
          igap--;
        end else begin
          in_valid = 1'b1;
          icons++;
          if (icons < total) begin
            igap = int'($urandom_range(imax));
            exp_stall += igap;
          end
        end
      end else begin
        in_valid = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (!aborted) repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    if ({k_ready, in_ready, buf4x4_we, buf_addr, sel, Mac_en, Mac_rst, shift_rst,
         shift_write, shif_shift, wr, addr, busy, done} !== '0) begin
      $display("FAIL reset_outputs: got %h, required all zero",
               {k_ready, in_ready, buf4x4_we, buf_addr, sel, Mac_en, Mac_rst, shift_rst,
                shift_write, shif_shift, wr, addr, busy, done});
      errors++;
    end
    checks++;
`ifdef PE_SEQ_PERF_EN
    if (perf_stall !== 16'd0) begin
      $display("FAIL reset_perf: got %0d, required 0", perf_stall); errors++;
    end
    checks++;
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    if ({busy, k_ready, done} !== 3'b000) begin
      $display("FAIL idle_after_reset: busy/k_ready/done got %b, required 000", {busy, k_ready, done});
      errors++;
    end
    checks++;
  endtask

  task automatic test_full_word;
    int kg, st;
    bit ab;
    run_job(4, 0, 0, -1, -1, kg, st, ab);
    if (we_cnt !== K_WORDS || we_bad !== 0) begin
      $display("FAIL full_kload: writes %0d bad_addr %0d, required %0d and 0", we_cnt, we_bad, K_WORDS);
      errors++;
    end
    checks++;
    if (mac_cnt !== 64) begin
      $display("FAIL full_mac_en: got %0d, required 64", mac_cnt); errors++;
    end
    checks++;
    if (sw_cnt !== 4 || ss_bad !== 0) begin
      $display("FAIL full_shift_write: got %0d (no-shift %0d), required 4 (0)", sw_cnt, ss_bad); errors++;
    end
    checks++;
    if (wr_addr.size() !== 1 || wr_addr[0] !== 0) begin
      $display("FAIL full_wr: count %0d first addr %0d, required 1 at 0", wr_addr.size(),
               (wr_addr.size() > 0) ? wr_addr[0] : -1);
      errors++;
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== exp_done_cyc(4, kg, st)) begin
      $display("FAIL full_done: count %0d at cycle %0d, required 1 at %0d", done_cnt, done_cyc,
               exp_done_cyc(4, kg, st));
      errors++;
    end
    checks++;
    if (done_busy_bad !== 0 || busy !== 1'b0) begin
      $display("FAIL full_busy: busy with done %0d, busy now %b, required 0 and 0", done_busy_bad, busy);
      errors++;
    end
    checks++;
  endtask

  task automatic test_partial_word;
    int kg, st;
    bit ab;
    run_job(6, 1, 1, -1, -1, kg, st, ab);
    if (sw_cnt !== 6) begin
      $display("FAIL partial_shift_write: got %0d, required 6", sw_cnt); errors++;
    end
    checks++;
    if (wr_addr.size() !== 2) begin
      $display("FAIL partial_wr_count: got %0d, required 2", wr_addr.size()); errors++;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_addr[i] !== i || wr_bytes[i] !== ((i == 0) ? BPW : 2)) begin
          $display("FAIL partial_word%0d: addr %0d bytes %0d, required addr %0d bytes %0d",
                   i, wr_addr[i], wr_bytes[i], i, (i == 0) ? BPW : 2);
          errors++;
        end
        checks++;
      end
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== exp_done_cyc(6, kg, st)) begin
      $display("FAIL partial_done: count %0d at cycle %0d, required 1 at %0d", done_cnt, done_cyc,
               exp_done_cyc(6, kg, st));
      errors++;
    end
    checks++;
  endtask

  task automatic test_stall;
    int kg, st;
    bit ab;
    run_job(3, 2, 3, -1, -1, kg, st, ab);
    if (sel_bad !== 0) begin
      $display("FAIL stall_sel: %0d cycles with wrong tap select, required 0", sel_bad); errors++;
    end
    checks++;
    if (mac_cnt !== 3 * TAPS) begin
      $display("FAIL stall_mac_en: got %0d, required %0d", mac_cnt, 3 * TAPS); errors++;
    end
    checks++;
    if (done_cyc !== exp_done_cyc(3, kg, st)) begin
      $display("FAIL stall_done_cycle: got %0d, required %0d", done_cyc, exp_done_cyc(3, kg, st));
      errors++;
    end
    checks++;
`ifdef PE_SEQ_PERF_EN
    if (int'(perf_stall) !== st) begin
      $display("FAIL stall_perf: got %0d, required %0d", perf_stall, st); errors++;
    end
    checks++;
`endif
  endtask

  task automatic test_busy_start;
    int kg, st;
    bit ab;
    run_job(2, 0, 1, 20, -1, kg, st, ab);
    if (sw_cnt !== 2 || wr_addr.size() !== 1) begin
      $display("FAIL busy_start_windows: shift_write %0d wr %0d, required 2 and 1", sw_cnt, wr_addr.size());
      errors++;
    end
    checks++;
    if (done_cnt !== 1) begin
      $display("FAIL busy_start_done: got %0d, required 1", done_cnt); errors++;
    end
    checks++;
  endtask

  task automatic test_zero_windows;
    int kg, st;
    bit ab;
    run_job(0, 1, 0, -1, -1, kg, st, ab);
    if (we_cnt !== K_WORDS || we_bad !== 0) begin
      $display("FAIL zero_kload: writes %0d bad_addr %0d, required %0d and 0", we_cnt, we_bad, K_WORDS);
      errors++;
    end
    checks++;
    if (wr_addr.size() !== 0 || sw_cnt !== 0 || mac_cnt !== 0) begin
      $display("FAIL zero_no_store: wr %0d shift_write %0d mac %0d, required 0 0 0",
               wr_addr.size(), sw_cnt, mac_cnt);
      errors++;
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== exp_done_cyc(0, kg, st) || busy !== 1'b0) begin
      $display("FAIL zero_done: count %0d at cycle %0d busy %b, required 1 at %0d busy 0",
               done_cnt, done_cyc, busy, exp_done_cyc(0, kg, st));
      errors++;
    end
    checks++;
  endtask

  task automatic test_mid_reset;
    int kg, st;
    bit ab;
    run_job(2, 1, 1, -1, 7, kg, st, ab);
    if (ab !== 1'b1) begin
      $display("FAIL mid_reset_reach_tap7: got %b, required 1", ab); errors++;
    end
    checks++;
    rst = 1'b0;
    @(negedge clk);
    if ({k_ready, in_ready, buf4x4_we, buf_addr, sel, Mac_en, Mac_rst, shift_rst,
         shift_write, shif_shift, wr, addr, busy, done} !== '0) begin
      $display("FAIL mid_reset_outputs: got %h, required all zero",
               {k_ready, in_ready, buf4x4_we, buf_addr, sel, Mac_en, Mac_rst, shift_rst,
                shift_write, shif_shift, wr, addr, busy, done});
      errors++;
    end
    checks++;
    @(posedge clk); #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    k_valid  = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    if (done_cnt !== 0 || wr_addr.size() !== 0) begin
      $display("FAIL mid_reset_no_done: done %0d wr %0d, required 0 and 0", done_cnt, wr_addr.size());
      errors++;
    end
    checks++;
    run_job(1, 0, 0, -1, -1, kg, st, ab);
    if (we_cnt !== K_WORDS || we_bad !== 0 || done_cnt !== 1) begin
      $display("FAIL mid_reset_restart: writes %0d bad_addr %0d done %0d, required %0d 0 1",
               we_cnt, we_bad, done_cnt, K_WORDS);
      errors++;
    end
    checks++;
  endtask

  task automatic test_random_jobs;
    int kg, st, nw, left;
    bit ab;
    for (int j = 0; j < 4; j++) begin
      nw = int'($urandom_range(9, 1));
      run_job(nw, 2, 2, -1, -1, kg, st, ab);
      if (mac_cnt !== nw * TAPS || sw_cnt !== nw || sel_bad !== 0) begin
        $display("FAIL rand%0d_mac: mac %0d sw %0d sel_bad %0d, required %0d %0d 0",
                 j, mac_cnt, sw_cnt, sel_bad, nw * TAPS, nw);
        errors++;
      end
      checks++;
      if (wr_addr.size() !== (nw + BPW - 1) / BPW) begin
        $display("FAIL rand%0d_wr_count: got %0d, required %0d", j, wr_addr.size(), (nw + BPW - 1) / BPW);
        errors++;
      end else begin
        left = nw;
        for (int i = 0; i < wr_addr.size(); i++) begin
          if (wr_addr[i] !== i || wr_bytes[i] !== ((left < BPW) ? left : BPW)) begin
            $display("FAIL rand%0d_word%0d: addr %0d bytes %0d, required %0d %0d",
                     j, i, wr_addr[i], wr_bytes[i], i, (left < BPW) ? left : BPW);
            errors++;
          end
          checks++;
          left -= BPW;
        end
      end
      checks++;
      if (done_cnt !== 1 || done_cyc !== exp_done_cyc(nw, kg, st)) begin
        $display("FAIL rand%0d_done: count %0d at %0d, required 1 at %0d",
                 j, done_cnt, done_cyc, exp_done_cyc(nw, kg, st));
        errors++;
      end
      checks++;
`ifdef PE_SEQ_PERF_EN
      if (int'(perf_stall) !== st) begin
        $display("FAIL rand%0d_perf: got %0d, required %0d", j, perf_stall, st); errors++;
      end
      checks++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial_word();
    test_stall();
    test_busy_start();
    test_zero_windows();
    test_mid_reset();
    test_random_jobs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
